// File: rtl/gpu_cmd_queue.sv
// Command front end: buffers host words in a circular FIFO and assembles
// header + NUM_VERTS vertex words into one wide command for the rasteriser.
module gpu_cmd_queue #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned COORD_W   = 16,
  parameter int unsigned TEX_W     = 8,
  parameter int unsigned NUM_VERTS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fifo_write,
  input  logic [DATA_W-1:0]              fifo_write_data,
  output logic                           fifo_full,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [3:0]                     cmd_op,
  output logic [TEX_W-1:0]               cmd_tex,
  output logic [NUM_VERTS*COORD_W-1:0]   cmd_x,
  output logic [NUM_VERTS*COORD_W-1:0]   cmd_y,
  output logic                           overflow,
  output logic                           err_opcode,
  output logic                           busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {IDLE, VERT, OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [IW-1:0]     idx;

  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] head_c;
  logic [3:0]        head_op_c;
  logic [CW-1:0]     count_nxt_c;

  // Full is the registered flag, so a push is judged before any same-cycle pop.
  always_comb begin
    head_c      = mem[rd_ptr];
    head_op_c   = head_c[DATA_W-1 -: 4];
    push_c      = fifo_write && !fifo_full;
    pop_c       = (count != '0) && (state != OUT);
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (!push_c && pop_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= fifo_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      err_opcode <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_tex    <= '0;
      cmd_x      <= '0;
      cmd_y      <= '0;
    end else begin
      overflow   <= fifo_write && fifo_full;
      err_opcode <= 1'b0;
      count      <= count_nxt_c;
      fifo_full  <= (count_nxt_c == CW'(DEPTH));
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case (state)
        IDLE: begin
          if (pop_c) begin
            if (head_op_c <= 4'd1) begin
              cmd_op  <= head_op_c;
              cmd_tex <= head_c[TEX_W-1:0];
              idx     <= '0;
              state   <= VERT;
            end else if (head_op_c == 4'd2) begin
              cmd_op    <= 4'd2;
              cmd_tex   <= '0;
              cmd_x     <= '0;
              cmd_y     <= '0;
              cmd_valid <= 1'b1;
              state     <= OUT;
            end else begin
              err_opcode <= 1'b1;
            end
          end
        end
        VERT: begin
          if (pop_c) begin
            cmd_x[idx*COORD_W +: COORD_W] <= head_c[2*COORD_W-1:COORD_W];
            cmd_y[idx*COORD_W +: COORD_W] <= head_c[COORD_W-1:0];
            idx <= idx + IW'(1);
            if (idx == IW'(NUM_VERTS - 1)) begin
              cmd_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue: per-cycle vector table plus sequences for
// full/overflow, count-hold with wrap, and a NUM_VERTS=4 / COORD_W=12 instance.
module tb_gpu_cmd_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fifo_write;
  logic [31:0] fifo_write_data;
  logic        cmd_ready;
  logic        fifo_full;
  logic [4:0]  fifo_count;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_tex;
  logic [47:0] cmd_x;
  logic [47:0] cmd_y;
  logic        overflow;
  logic        err_opcode;
  logic        busy;

  logic        w4;
  logic [31:0] d4;
  logic        r4;
  logic        full4;
  logic [4:0]  cnt4;
  logic        valid4;
  logic [3:0]  op4;
  logic [7:0]  tex4;
  logic [47:0] x4;
  logic [47:0] y4;
  logic        ovf4;
  logic        err4;
  logic        busy4;

  gpu_cmd_queue u_dut (
    .clk(clk), .reset(reset), .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_tex(cmd_tex), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .overflow(overflow), .err_opcode(err_opcode), .busy(busy)
  );

  gpu_cmd_queue #(.NUM_VERTS(4), .COORD_W(12)) u_dut4 (
    .clk(clk), .reset(reset), .fifo_write(w4), .fifo_write_data(d4),
    .fifo_full(full4), .fifo_count(cnt4), .cmd_valid(valid4), .cmd_ready(r4),
    .cmd_op(op4), .cmd_tex(tex4), .cmd_x(x4), .cmd_y(y4),
    .overflow(ovf4), .err_opcode(err4), .busy(busy4)
  );

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [31:0] data;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_count;
    logic        e_busy;
    logic        e_err;
    logic        chk_cmd;
    logic [3:0]  e_op;
    logic [7:0]  e_tex;
    logic [47:0] e_x;
    logic [47:0] e_y;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  tex;
    logic [47:0] x;
    logic [47:0] y;
  } cmd_t;

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[24];
  cmd_t        got[$];
  cmd_t        exp_q[$];
  logic [31:0] wq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] d, input logic rd,
                              input logic v, input logic [4:0] c, input logic b, input logic e);
    vec_t t;
    t.rst_n = r; t.wr = w; t.data = d; t.rdy = rd;
    t.e_valid = v; t.e_count = c; t.e_busy = b; t.e_err = e;
    t.chk_cmd = 1'b0; t.e_op = '0; t.e_tex = '0; t.e_x = '0; t.e_y = '0;
    return t;
  endfunction

  // Capture any command the coming edge will accept, then drive and advance.
  task automatic step(input logic wr, input logic [31:0] d, input logic rdy);
    cmd_t c;
    if (cmd_valid && rdy) begin
      c.op = cmd_op; c.tex = cmd_tex; c.x = cmd_x; c.y = cmd_y;
      got.push_back(c);
    end
    fifo_write = wr; fifo_write_data = d; cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic add_draw(input logic [3:0] op, input logic [7:0] tex, input int seed);
    cmd_t c;
    c.op = op; c.tex = tex; c.x = '0; c.y = '0;
    wq.push_back({op, 20'h5A5A5, tex});
    for (int i = 0; i < 3; i++) begin
      logic [15:0] xv;
      logic [15:0] yv;
      xv = 16'(seed + i);
      yv = 16'(seed + i + 100);
      wq.push_back({xv, yv});
      c.x[i*16 +: 16] = xv;
      c.y[i*16 +: 16] = yv;
    end
    exp_q.push_back(c);
  endtask

  task automatic add_end();
    cmd_t c;
    c.op = 4'd2; c.tex = '0; c.x = '0; c.y = '0;
    wq.push_back(32'h2000_0000);
    exp_q.push_back(c);
  endtask

  // Push remaining words whenever not full with ready held, then compare.
  task automatic run_stream(input string tag, input int budget);
    int cyc;
    logic wr;
    cyc = 0;
    while ((wq.size() > 0 || got.size() < exp_q.size()) && cyc < budget) begin
      wr = (wq.size() > 0) && !fifo_full;
      step(wr, wr ? wq[0] : 32'h0, 1'b1);
      if (wr) void'(wq.pop_front());
      cyc++;
    end
    check({tag, "_ncmd"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_cmd%0d", tag, i),
            {got[i].op, got[i].tex, got[i].x, got[i].y},
            {exp_q[i].op, exp_q[i].tex, exp_q[i].x, exp_q[i].y});
    end
    got.delete(); exp_q.delete(); wq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; fifo_write = 1'b0; fifo_write_data = '0; cmd_ready = 1'b0;
    w4 = 1'b0; d4 = '0; r4 = 1'b0;

    //          rst  wr   data          rdy  valid cnt busy err
    vecs[0]  = mk(0, 0, 32'h0,         0,   0,  0,  0,  0);
    vecs[1]  = mk(1, 1, 32'h1000_0001, 0,   0,  1,  1,  0);
    vecs[2]  = mk(1, 1, 32'h000A_000A, 0,   0,  1,  1,  0);
    vecs[3]  = mk(1, 1, 32'h000A_006E, 0,   0,  1,  1,  0);
    vecs[4]  = mk(1, 1, 32'h006E_000A, 0,   0,  1,  1,  0);
    vecs[5]  = mk(1, 0, 32'h0,         0,   1,  0,  1,  0);
    vecs[6]  = mk(1, 0, 32'h0,         1,   0,  0,  0,  0);
    vecs[7]  = mk(1, 1, 32'h7000_0003, 0,   0,  1,  1,  0);
    vecs[8]  = mk(1, 1, 32'h1000_0005, 0,   0,  1,  1,  1);
    vecs[9]  = mk(1, 1, 32'h0001_0002, 0,   0,  1,  1,  0);
    vecs[10] = mk(1, 1, 32'h0003_0004, 0,   0,  1,  1,  0);
    vecs[11] = mk(1, 1, 32'h0005_0006, 0,   0,  1,  1,  0);
    vecs[12] = mk(1, 0, 32'h0,         0,   1,  0,  1,  0);
    vecs[13] = mk(1, 0, 32'h0,         1,   0,  0,  0,  0);
    vecs[14] = mk(1, 1, 32'h0000_0009, 0,   0,  1,  1,  0);
    vecs[15] = mk(1, 1, 32'h0011_0022, 0,   0,  1,  1,  0);
    vecs[16] = mk(1, 0, 32'h0,         0,   0,  0,  1,  0);
    vecs[17] = mk(0, 0, 32'h0,         0,   0,  0,  0,  0);
    vecs[18] = mk(1, 1, 32'h1000_0002, 0,   0,  1,  1,  0);
    vecs[19] = mk(1, 1, 32'h0007_0008, 0,   0,  1,  1,  0);
    vecs[20] = mk(1, 1, 32'h0009_000A, 0,   0,  1,  1,  0);
    vecs[21] = mk(1, 1, 32'h000B_000C, 0,   0,  1,  1,  0);
    vecs[22] = mk(1, 0, 32'h0,         0,   1,  0,  1,  0);
    vecs[23] = mk(1, 0, 32'h0,         1,   0,  0,  0,  0);
    vecs[5].chk_cmd  = 1'b1; vecs[5].e_op  = 4'd1; vecs[5].e_tex  = 8'd1;
    vecs[5].e_x  = 48'h006E_000A_000A; vecs[5].e_y  = 48'h000A_006E_000A;
    vecs[12].chk_cmd = 1'b1; vecs[12].e_op = 4'd1; vecs[12].e_tex = 8'd5;
    vecs[12].e_x = 48'h0005_0003_0001; vecs[12].e_y = 48'h0006_0004_0002;
    vecs[22].chk_cmd = 1'b1; vecs[22].e_op = 4'd1; vecs[22].e_tex = 8'd2;
    vecs[22].e_x = 48'h000B_0009_0007; vecs[22].e_y = 48'h000C_000A_0008;

    for (int i = 0; i < 24; i++) begin
      reset = vecs[i].rst_n;
      step(vecs[i].wr, vecs[i].data, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 128'(cmd_valid), 128'(vecs[i].e_valid));
      check($sformatf("v%0d_count", i), 128'(fifo_count), 128'(vecs[i].e_count));
      check($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].e_busy));
      check($sformatf("v%0d_err", i), 128'(err_opcode), 128'(vecs[i].e_err));
      check($sformatf("v%0d_ovf_full", i), 128'({overflow, fifo_full}), 128'(0));
      if (vecs[i].chk_cmd) begin
        check($sformatf("v%0d_cmd", i), {cmd_op, cmd_tex, cmd_x, cmd_y},
              {vecs[i].e_op, vecs[i].e_tex, vecs[i].e_x, vecs[i].e_y});
      end
    end
    got.delete();

    // Fill to full with one packet parked in OUT, then overflow.
    do_reset();
    for (int p = 0; p < 5; p++) add_draw(4'(p % 2), 8'(p + 1), p * 10);
    for (int i = 0; i < 20; i++) step(1'b1, wq[i], 1'b0);
    wq.delete();
    check("full_flag", 128'(fifo_full), 128'(1));
    check("full_count", 128'(fifo_count), 128'(16));
    step(1'b1, 32'h2000_0000, 1'b0);
    check("ovf_pulse", 128'(overflow), 128'(1));
    check("ovf_count", 128'(fifo_count), 128'(16));
    step(1'b0, 32'h0, 1'b0);
    check("ovf_drop", 128'(overflow), 128'(0));
    add_end();
    run_stream("drain", 300);

    // Push and pop together at count 5, then stream 40 words for pointer wrap.
    do_reset();
    for (int p = 0; p < 10; p++) add_draw(4'(p % 2), 8'(8'h40 + p), 1000 + p * 7);
    for (int i = 0; i < 9; i++) step(1'b1, wq.pop_front(), 1'b0);
    check("hold_count5", 128'(fifo_count), 128'(5));
    step(1'b0, 32'h0, 1'b1);
    check("accept_count5", 128'(fifo_count), 128'(5));
    check("accept_valid", 128'(cmd_valid), 128'(0));
    step(1'b1, wq.pop_front(), 1'b0);
    check("pushpop_count5", 128'(fifo_count), 128'(5));
    run_stream("wrap", 500);
    check("wrap_idle", 128'({busy, fifo_count}), 128'(0));

    // Four-vertex, 12-bit instance; stray high bits must be ignored.
    w4 = 1'b1;
    d4 = 32'h0ABC_DE03; step(1'b0, 32'h0, 1'b0);
    d4 = 32'hFF00_1002; step(1'b0, 32'h0, 1'b0);
    d4 = 32'h0000_3004; step(1'b0, 32'h0, 1'b0);
    d4 = 32'h0000_5006; step(1'b0, 32'h0, 1'b0);
    d4 = 32'h0000_7008; step(1'b0, 32'h0, 1'b0);
    w4 = 1'b0;
    check("nv4_early", 128'(valid4), 128'(0));
    step(1'b0, 32'h0, 1'b0);
    check("nv4_valid", 128'(valid4), 128'(1));
    check("nv4_cmd", {op4, tex4, x4, y4}, {4'd0, 8'h03, 48'h0070_0500_3001, 48'h0080_0600_4002});
    r4 = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    r4 = 1'b0;
    check("nv4_done", 128'({valid4, busy4}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
